mul_sum_stage: RTL and testbench
================================

MUL_SUM_STAGE -- requirements
Module: mul_sum_stage

Interface
REQ-001 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: in_valid  in  1  carry-save pair presented by the wallace tree bank.
REQ-004 SHALL have port: in_ready  out  1  stage accepts the pair this cycle.
REQ-005 SHALL have port: tree_s  in  64  per-bit S outputs of the 64 wallace slices, bit i has weight 2^i.
REQ-006 SHALL have port: tree_c  in  64  per-bit C outputs of the 64 wallace slices, bit i has weight 2^(i+1).
REQ-007 SHALL have port: tree_cin  in  1  residual booth carry injected at weight 2^0.
REQ-008 SHALL have port: flush  in  1  synchronous cancel of all in-flight operations.
REQ-009 SHALL have port: out_valid  out  1  result holds a finished product.
REQ-010 SHALL have port: out_ready  in  1  consumer takes the result this cycle.
REQ-011 SHALL have port: result  out  64  final product, {hi32, lo32}.

Function
REQ-012 SHALL compute result = (tree_s + {tree_c[62:0], tree_cin}) mod 2^64; tree_c[63] is discarded.
REQ-013 SHALL transfer input when in_valid && in_ready, and output when out_valid && out_ready, on the same rising edge.
REQ-014 SHALL hold result and out_valid stable while out_valid && !out_ready.
REQ-015 SHALL implement each pipeline stage as a valid bit plus data register; stage ready = !valid || next-stage ready.
REQ-016 SHALL drive in_ready = ready of the first stage (combinational from out_ready through the stage chain, no bubble).
REQ-017 SHALL sustain one accepted pair per cycle when out_ready is held high.
REQ-018 SHALL, with split enabled, compute in stage 1 lo32 = tree_s[31:0] + {tree_c[30:0], tree_cin} and register lo32, carry-out c32, tree_s[63:32], tree_c[62:31].
REQ-019 SHALL, with split enabled, compute in stage 2 hi32 = s_hi + c_hi + c32 and register {hi32, lo32} as result.
REQ-020 SHALL, on flush, clear every stage valid bit at the next edge, discard any input accepted that same edge, and force in_ready high the following cycle.
REQ-021 SHALL give flush priority over a simultaneous input or output transfer (output transfer in the flush cycle still counts as taken by the consumer).
REQ-022 SHALL leave data registers unchanged when their stage does not load (no gratuitous toggling).

Reset
REQ-023 SHALL, while resetn is low, force all valid bits 0, result 0, internal carry and data registers 0.
REQ-024 SHALL drive in_ready 1 and out_valid 0 during and immediately after reset.
REQ-025 SHALL drop any in-flight operation when resetn asserts mid-operation; no partial result SHALL appear after release.

Configuration
REQ-026 SHALL recognise macro MUL_SUM_SPLIT_EN.
REQ-027 SHALL, with MUL_SUM_SPLIT_EN defined, use the two-stage split adder: latency 2 cycles from accept to out_valid.
REQ-028 SHALL, without MUL_SUM_SPLIT_EN, use one full 64-bit add registered directly into result: latency 1 cycle; handshake, reset and flush rules unchanged.

Verification
REQ-029 Reset: resetn low 3 cycles, in_valid high -> out_valid 0, result 0, in_ready 1, no transfer accepted.
REQ-030 Basic: tree_s=64'h0000_0000_FFFF_FFFF, tree_c=0, tree_cin=1, out_ready=1 -> result 64'h0000_0001_0000_0000 after 2 cycles (split) / 1 cycle (unsplit), out_valid pulse of 1 cycle.
REQ-031 Carry chain: tree_s=64'hFFFF_FFFF_FFFF_FFFF, tree_c=0, tree_cin=1 -> result 0; tree_c[63]=1 alone -> result 0 (bit dropped).
REQ-032 Back-pressure: 4 back-to-back pairs (1+1, 2+2, 3+3, 4+4 via tree_s=k, tree_c=k>>1 form), out_ready low 3 cycles mid-stream -> in_ready low while full, results 2,4,6,8 delivered in order, none lost or duplicated.
REQ-033 Flush: accept 2 pairs, assert flush 1 cycle with in_valid high -> out_valid 0 next cycle, next accepted pair 5+0 yields result 5 only.
REQ-034 Random: 10k random tree_s/tree_c/tree_cin with random in_valid/out_ready -> every result matches reference sum mod 2^64, order preserved, in both macro settings.

Source files
------------

// File: rtl/mul_sum_stage_if.sv
// mul_sum_stage_if -- handshake and data bundle for mul_sum_stage.
// The slave modport is the stage's own view; the master modport is the
// view of whoever drives the carry-save pair and consumes the product.
interface mul_sum_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] tree_s;
  logic [63:0] tree_c;
  logic        tree_cin;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  modport slave (
    input  in_valid, tree_s, tree_c, tree_cin, flush, out_ready,
    output in_ready, out_valid, result
  );

  modport master (
    output in_valid, tree_s, tree_c, tree_cin, flush, out_ready,
    input  in_ready, out_valid, result
  );
endinterface

// File: rtl/mul_sum_stage.sv
// mul_sum_stage -- final carry-propagate adder behind the wallace tree bank.
// Adds the carry-save pair (tree_s, tree_c shifted up by one, tree_cin at
// weight 1) into a 64-bit product {hi32, lo32}.
// Optional macro MUL_SUM_SPLIT_EN: when defined, the add is split into two
// 32-bit halves over two pipeline stages (latency 2); when undefined, one
// 64-bit add feeds the result register directly (latency 1).
// Each stage is a valid bit plus data register; ready ripples back
// combinationally from out_ready so a full pipe with out_ready high still
// accepts one pair per cycle. flush cancels everything in flight.
module mul_sum_stage (
  input  logic           clk,
  input  logic           resetn,
  mul_sum_stage_if.slave bus
);

  // Bit 63 of tree_c has weight 2^64 and falls outside the product.
  logic unused_c63;
  assign unused_c63 = bus.tree_c[63];

  // Output stage (the result register), shared by both configurations.
  logic        out_valid_q, out_valid_d;
  logic [63:0] result_q,    result_d;
  logic        out_ready_up;   // output stage can take a new entry
  logic        out_load;       // output stage captures new data this edge

  assign out_ready_up  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

`ifdef MUL_SUM_SPLIT_EN

  // Stage 1 payload: low half already summed, high half still carry-save.
  typedef struct packed {
    logic [31:0] lo;
    logic        c32;
    logic [31:0] s_hi;
    logic [31:0] c_hi;
  } split_t;

  logic   s1_valid_q, s1_valid_d;
  split_t s1_data_q,  s1_data_d;
  logic   s1_ready;
  logic   s1_load;
  logic   [32:0] lo_sum;
  logic   [31:0] hi_sum;

  assign s1_ready     = !s1_valid_q || out_ready_up;
  assign bus.in_ready = s1_ready;
  // A pair accepted on a flush edge is dropped, so its data need not load.
  assign s1_load      = bus.in_valid && s1_ready && !bus.flush;
  assign out_load     = s1_valid_q && out_ready_up && !bus.flush;

  // Low-half add: tree_c is pre-shifted, so its bits 30:0 land on 31:1.
  assign lo_sum = {1'b0, bus.tree_s[31:0]} + {1'b0, bus.tree_c[30:0], bus.tree_cin};
  // High-half add finishes the carry chain from the registered c32.
  assign hi_sum = s1_data_q.s_hi + s1_data_q.c_hi + {31'd0, s1_data_q.c32};

  // Stage 1 next-state: valid follows the input whenever the slot frees up.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and a latch can never be inferred.
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    if (bus.flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_ready) begin
      s1_valid_d = bus.in_valid;
    end
    if (s1_load) begin
      s1_data_d.lo   = lo_sum[31:0];
      s1_data_d.c32  = lo_sum[32];
      s1_data_d.s_hi = bus.tree_s[63:32];
      s1_data_d.c_hi = bus.tree_c[62:31];
    end
  end

  // Output stage next-state: combine the halves when stage 1 moves on.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (out_ready_up) begin
      out_valid_d = s1_valid_q;
    end
    if (out_load) begin
      result_d = {hi_sum, s1_data_q.lo};
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: data registers are reset along with the valid bits so no stale
    // partial sum can be observed after reset; they are few and cheap.
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

`else

  logic [63:0] full_sum;

  assign bus.in_ready = out_ready_up;
  assign out_load     = bus.in_valid && out_ready_up && !bus.flush;
  assign full_sum     = bus.tree_s + {bus.tree_c[62:0], bus.tree_cin};

  // Output stage next-state: single full-width add straight into result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and a latch can never be inferred.
    out_valid_d = out_valid_q;
    result_d    = result_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (out_ready_up) begin
      out_valid_d = bus.in_valid;
    end
    if (out_load) begin
      result_d = full_sum;
    end
  end

`endif

  // Output stage registers; result only changes when a new sum is loaded.
  always_ff @(posedge clk or negedge resetn) begin
`ifndef MUL_SUM_SPLIT_EN
    // NOTE: the result register is reset with the valid bit so no stale
    // product can be observed after reset.
`endif
    if (!resetn) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
`ifndef MUL_SUM_SPLIT_EN
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
`endif
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  // A stalled result must not change or disappear unless flushed.
  a_hold_stable: assert property (
    @(posedge clk) disable iff (!resetn)
    (out_valid_q && !bus.out_ready && !bus.flush) |=> (out_valid_q && $stable(result_q))
  );

  // After a flush every stage is empty, so the pipe must be ready.
  a_flush_ready: assert property (
    @(posedge clk) disable iff (!resetn)
    bus.flush |=> bus.in_ready
  );

endmodule

// File: tb/tb_mul_sum_stage.sv
// tb_mul_sum_stage -- self-checking bench for mul_sum_stage.
// A queue model tracks every accepted pair with its expected sum and age;
// the head is visible once it is old enough, and the pipe is ready while it
// holds fewer entries than its depth or the consumer is taking the head.
// Build with +define+MUL_SUM_SPLIT_EN for the two-stage configuration.
module tb_mul_sum_stage;

`ifdef MUL_SUM_SPLIT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  mul_sum_stage_if bus ();

  mul_sum_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] ref_sum(input logic [63:0] s, input logic [63:0] c,
                                          input logic cin);
    return s + (c << 1) + {63'd0, cin};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] val;
    int          age;
  } item_t;

  item_t       q[$];
  bit          l_in, l_out, l_flush;
  logic [63:0] l_sum;

  // Compare process: outputs are checked mid-cycle, and the handshakes that
  // will complete on the coming edge are latched for the model update.
  always @(negedge clk) begin
    if (!resetn) begin
      q.delete();
      l_in    = 1'b0;
      l_out   = 1'b0;
      l_flush = 1'b0;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready",  bus.in_ready,  1'b1);
      check("rst_result",    bus.result,    64'd0);
    end else begin
      bit exp_v, exp_r;
      exp_v = (q.size() > 0) && (q[0].age >= LAT - 1);
      exp_r = (q.size() < LAT) || bus.out_ready;
      check("out_valid", bus.out_valid, exp_v);
      check("in_ready",  bus.in_ready,  exp_r);
      if (exp_v) check("result", bus.result, q[0].val);
      l_in    = bus.in_valid && bus.in_ready;
      l_out   = bus.out_valid && bus.out_ready;
      l_flush = bus.flush;
      l_sum   = ref_sum(bus.tree_s, bus.tree_c, bus.tree_cin);
    end
  end

  // Model update on the active edge.
  always @(posedge clk) begin
    if (resetn) begin
      if (l_flush) begin
        q.delete();
      end else begin
        if (l_out && q.size() > 0) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (l_in) q.push_back('{val: l_sum, age: 0});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] s, input logic [63:0] c, input logic cin);
    bus.in_valid = 1'b1;
    bus.tree_s   = s;
    bus.tree_c   = c;
    bus.tree_cin = cin;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
    timeout("send");
  endtask

  // Waits for out_valid, checks the literal result and the cycles taken.
  task automatic wait_result(input logic [63:0] exp, input string name, output int lat);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        check(name, bus.result, exp);
        return;
      end
      lat++;
    end
    timeout(name);
  endtask

  task automatic run_one(input logic [63:0] s, input logic [63:0] c, input logic cin,
                         input logic [63:0] exp, input string name);
    int lat;
    send(s, c, cin);
    wait_result(exp, name, lat);
    step();
  endtask

  logic [63:0] got_q[$];
  bit          saw_full;
  int          lat;
  int          cnt;

  initial begin
    bus.in_valid  = 1'b1;
    bus.tree_s    = 64'h1234_5678_9ABC_DEF0;
    bus.tree_c    = 64'h0F0F_0F0F_0F0F_0F0F;
    bus.tree_cin  = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset with in_valid high: nothing may be accepted.
    resetn = 1'b0;
    repeat (3) step();
    bus.in_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", bus.out_valid, 1'b0);
    check("post_rst_in_ready",  bus.in_ready,  1'b1);
    check("post_rst_result",    bus.result,    64'd0);
    step();

    // Basic carry across the half boundary, with latency and pulse width.
    send(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1);
    wait_result(64'h0000_0001_0000_0000, "basic", lat);
    check("basic_latency", lat, LAT - 1);
    @(negedge clk);
    check("basic_pulse", bus.out_valid, 1'b0);
    step();

    // Full-width carry chain wraps to zero; tree_c[63] is dropped.
    run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, "carry_wrap");
    run_one(64'd0, 64'h8000_0000_0000_0000, 1'b0, 64'd0, "c63_drop");
    run_one(64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000, 1'b0,
            64'h0000_0001_0000_0000, "c_shift");

    // Back-pressure: four back-to-back pairs, consumer stalls 3 cycles.
    got_q.delete();
    saw_full = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++) send(64'(k), 64'(k >> 1), 1'(k % 2));
      end
      begin
        repeat (2) step();
        bus.out_ready = 1'b0;
        repeat (3) step();
        bus.out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 40 && got_q.size() < 4; i++) begin
          @(negedge clk);
          if (!bus.in_ready) saw_full = 1'b1;
          if (bus.out_valid && bus.out_ready) got_q.push_back(bus.result);
        end
      end
    join
    check("bp_count", got_q.size(), 4);
    for (int i = 0; i < got_q.size() && i < 4; i++) check("bp_value", got_q[i], 64'(2 * (i + 1)));
    check("bp_saw_full", saw_full, 1'b1);
    step();

    // Flush with in_valid high cancels everything in flight.
    bus.out_ready = 1'b0;
    send(64'd10, 64'd0, 1'b0);
    if (LAT == 2) send(64'd20, 64'd0, 1'b0);
    bus.in_valid = 1'b1;
    bus.tree_s   = 64'd7;
    bus.tree_c   = 64'd0;
    bus.tree_cin = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 1'b0);
    check("flush_in_ready",  bus.in_ready,  1'b1);
    bus.out_ready = 1'b1;
    run_one(64'd5, 64'd0, 1'b0, 64'd5, "flush_next");
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("flush_no_extra", cnt, 0);
    step();

    // Reset in the middle of an operation: nothing may emerge afterwards.
    bus.out_ready = 1'b0;
    send(64'd123, 64'd0, 1'b0);
    resetn = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("midop_reset_no_output", cnt, 0);
    step();

    // Random traffic with random back-pressure and occasional flush.
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(2) != 0);
      bus.flush     = ($urandom_range(96) == 0);
      bus.tree_cin  = 1'($urandom);
      case ($urandom_range(7))
        0:       bus.tree_s = 64'hFFFF_FFFF_FFFF_FFFF;
        1:       bus.tree_s = {32'($urandom), 32'hFFFF_FFFF};
        default: bus.tree_s = {32'($urandom), 32'($urandom)};
      endcase
      bus.tree_c = {32'($urandom), 32'($urandom)};
      step();
    end

    // Drain.
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
